// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl
// Turns the bit-serial 1011_0101 pattern detector into a word-level scanning
// engine. Each word is taken over a valid/ready handshake. The detector is
// cleared for one cycle, and the word is then shifted out MSB-first, one bit
// per clock. Flags seen while shifting are counted, and the per-word count is
// returned over a second valid/ready handshake. A saturating total of all
// matches since reset is kept alongside.
module seq_scan_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4,
    parameter int TOT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             det_x,
    output logic             det_rst,
    input  logic             det_flag,
    output logic             out_valid,
    output logic [CNT_W-1:0] out_count,
    input  logic             out_ready,
    output logic             busy,
    output logic [TOT_W-1:0] total_matches
);

    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        SHIFT,
        REPORT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [BIT_W-1:0] bit_cnt;
    logic             accept;
    logic             shift_en;
    logic             count_en;

    // State register; rst aborts any word in flight and returns to IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake/detector outputs. The detector is held in
    // reset while the controller is, so both leave reset together.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        det_x     = 1'b0;
        det_rst   = ~rst;
        accept    = 1'b0;
        shift_en  = 1'b0;
        count_en  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                det_rst   = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                det_x    = shreg[WIDTH-1];
                shift_en = 1'b1;
                count_en = det_flag;
                if (bit_cnt == LAST_BIT) begin
                    state_nxt = REPORT;
                end
            end
            REPORT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Word shift register, bit counter and saturating match counters. The
    // flag belongs to the bit currently on det_x, so it is counted on the same
    // edge that shifts that bit out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg         <= '0;
            bit_cnt       <= '0;
            out_count     <= '0;
            total_matches <= '0;
        end else if (accept) begin
            shreg     <= in_data;
            bit_cnt   <= '0;
            out_count <= '0;
        end else if (shift_en) begin
            shreg   <= {shreg[WIDTH-2:0], 1'b0};
            bit_cnt <= bit_cnt + BIT_W'(1);
            if (count_en) begin
                if (out_count != '1) begin
                    out_count <= out_count + CNT_W'(1);
                end
                if (total_matches != '1) begin
                    total_matches <= total_matches + TOT_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/seq_scan_ctrl.md
# seq_scan_ctrl

Controller that sequences the bit-serial pattern detector (8-bit pattern 1011_0101, Mealy flag, overlap-resumes) as a word-level scanning engine. It accepts parallel words over a valid/ready handshake and clears the detector before each word. It then shifts the word into the detector MSB-first, one bit per clock, counts the flag pulses and returns the per-word match count over a second valid/ready handshake. It also keeps a running saturating total of all matches since reset.

## Interface
- WIDTH, 8, bits per scanned word (≥2)
- CNT_W, 4, width of per-word match count (saturating)
- TOT_W, 16, width of total match accumulator (saturating)

- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  word available
- in_data  input  WIDTH  word to scan; bit WIDTH-1 is sent first
- in_ready  output  1  controller can accept a word
- det_x  output  1  serial bit to detector x input
- det_rst  output  1  active-high synchronous reset to detector
- det_flag  input  1  detector flag (combinational in det_x, same cycle)
- out_valid  output  1  result available
- out_count  output  CNT_W  matches found in last word
- out_ready  input  1  result consumer ready
- busy  output  1  high in any state except IDLE
- total_matches  output  TOT_W  saturating count of all matches since reset

## Operation
- FSM states: IDLE, CLEAR, SHIFT, REPORT.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_data into shift register, zero bit counter and out_count, go to CLEAR.
- CLEAR:
  - det_rst=1 for exactly one cycle, det_x=0, go to SHIFT.
- SHIFT (WIDTH cycles):
  - det_x = shreg[WIDTH-1]; shreg shifts left by 1 each cycle; bit counter increments.
  - det_flag is sampled in the same cycle as the bit driving it.
  - Each flag increments out_count, saturating at 2^CNT_W-1, and increments total_matches, saturating at 2^TOT_W-1.
  - After the bit with counter = WIDTH-1, go to REPORT.
- REPORT:
  - out_valid=1; out_count held stable.
  - On out_ready=1: go to IDLE.
- Outside SHIFT: det_x=0 and det_flag is ignored.
- det_rst is also driven high combinationally while rst is low, so the detector is held reset alongside the controller.
- in_ready is low in all states except IDLE; a word presented while busy is held by the producer, never dropped.
- Back-to-back words are not gapless: every word starts from a cleared detector; no match spans two words.

## Timing
- Reset values (async, rst=0):
  - state=IDLE, in_ready=1, out_valid=0, out_count=0, total_matches=0, busy=0, det_x=0, det_rst=1.
- Accept at edge T (in_valid & in_ready):
  - T+1: CLEAR.
  - T+2 … T+WIDTH+1: SHIFT; MSB is driven at T+2.
  - T+WIDTH+2: out_valid rises.
- Latency from accept to out_valid is WIDTH+2 cycles. Minimum word period is WIDTH+3 cycles: result taken in the first REPORT cycle, next word accepted on the following edge.
- out_valid remains high and out_count remains constant until the out_ready handshake. out_valid drops the cycle after the handshake.
- A flag on the final SHIFT bit is included in out_count and total_matches.
- rst asserted mid-word (any state): immediate abort, all outputs at reset values, total_matches cleared. After release, scanning resumes from IDLE with no residual state.
- Saturation: counters hold at maximum and never wrap.

## Test plan
- Single match: WIDTH=8, in_data=8'b1011_0101 → det_x sequence 1,0,1,1,0,1,0,1 starting 2 cycles after accept; det_rst high 1 cycle before; out_valid 10 cycles after accept; out_count=1; total_matches=1.
- No match and clear check:
  - Stimulus: 8'h00, then 8'b1011_0101.
  - Required response: counts 0, then 1. No flag may be caused by the previous word's tail.
- Overlap: WIDTH=16, in_data=16'b1011_0101_1010_1000 → out_count=2 (flags on bits 8 and 13); with CNT_W=1 → out_count=1 (saturated), total_matches=2.
- Backpressure: hold out_ready=0 for 5 cycles in REPORT → out_valid=1 and out_count stable throughout, in_ready=0, busy=1; in_valid held meanwhile is accepted only on the cycle after the handshake.
- Reset mid-SHIFT:
  - Stimulus: pull rst low on the 3rd SHIFT cycle of 8'b1011_0101, then release.
  - During reset: out_valid=0, det_rst=1, total_matches=0.
  - After release, rescanning the same word gives out_count=1 and total_matches=1.
- Total saturation: TOT_W=2, four words 8'b1011_0101 → total_matches reads 1,2,3,3.
